// File: rtl/ikascc_bus_sequencer_pkg.sv
// Shared types and constants for the IKASCC host bus sequencer.
// Command word layout, FSM state encoding and tick counter width.
package ikascc_bus_sequencer_pkg;

  localparam int SEQ_CMD_W    = 22;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_ABLO_LSB = 8;
  localparam int CMD_ABHI_LSB = 16;
  localparam int CMD_RD_BIT   = 21;
  localparam int CNT_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RECOV  = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic       rd;
    logic [4:0] abhi;
    logic [7:0] ablo;
    logic [7:0] data;
  } seq_cmd_t;

endpackage

// File: rtl/ikascc_bus_sequencer_fifo.sv
// Synchronous command FIFO, depth 2**AW, asynchronous active-low reset.
// Ports: clk, rst_n, push, pop, din, dout (show-ahead), full, empty.
module ikascc_bus_sequencer_fifo #(
  parameter int AW = 2,
  parameter int W  = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when an entry leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ikascc_bus_sequencer.sv
// Host command sequencer replaying queued reads/writes on the IKASCC bus.
// Ports: host valid/ready command in, read result out, registered bus strobes/AB/DB.
module ikascc_bus_sequencer
  import ikascc_bus_sequencer_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter int SETUP_TK  = 1,
  parameter int STROBE_TK = 3,
  parameter int RECOV_TK  = 2
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST_n,
  input  logic       i_MCLK_PCEN_n,
  input  logic       i_CMD_VALID,
  output logic       o_CMD_READY,
  input  logic       i_CMD_RD,
  input  logic [4:0] i_CMD_ABHI,
  input  logic [7:0] i_CMD_ABLO,
  input  logic [7:0] i_CMD_DATA,
  output logic       o_RD_VALID,
  output logic [7:0] o_RD_DATA,
  output logic       o_BUSY,
  output logic       o_CS_n,
  output logic       o_RD_n,
  output logic       o_WR_n,
  output logic [4:0] o_ABHI,
  output logic [7:0] o_ABLO,
  output logic [7:0] o_DB,
  input  logic [7:0] i_DB,
  input  logic       i_DB_OE
);

  if (STROBE_TK < 2 || STROBE_TK > 15) begin : g_bad_strobe_tk
    $error("STROBE_TK must be within 2..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_TK - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_TK - 1);
  localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_TK - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seq_cmd_t         cmd_q, cmd_d;
  logic             cs_n_q, cs_n_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic     tick;
  logic     pop;
  logic     push;
  logic     fifo_full;
  logic     fifo_empty;
  seq_cmd_t fifo_din;
  seq_cmd_t fifo_dout;

  assign tick     = ~i_MCLK_PCEN_n;
  assign pop      = tick & (state_q == ST_IDLE) & ~fifo_empty;
  assign o_CMD_READY = ~fifo_full | pop;
  assign push     = i_CMD_VALID & o_CMD_READY;
  assign fifo_din = {i_CMD_RD, i_CMD_ABHI, i_CMD_ABLO, i_CMD_DATA};

  ikascc_bus_sequencer_fifo #(
    .AW (FIFO_AW),
    .W  (SEQ_CMD_W)
  ) u_fifo (
    .clk   (i_EMUCLK),
    .rst_n (i_RST_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    cs_n_d     = cs_n_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            cmd_d   = fifo_dout;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_d = ST_STROBE;
            cnt_d   = STROBE_LD;
            cs_n_d  = 1'b0;
            rd_n_d  = ~cmd_q.rd;
            wr_n_d  = cmd_q.rd;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            rd_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            if (cmd_q.rd) begin
              rd_valid_d = 1'b1;
              rd_data_d  = i_DB_OE ? i_DB : 8'hFF;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          state_d = ST_RECOV;
          cnt_d   = RECOV_LD;
        end
        ST_RECOV: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'hFF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_CS_n     = cs_n_q;
  assign o_RD_n     = rd_n_q;
  assign o_WR_n     = wr_n_q;
  assign o_ABHI     = cmd_q.abhi;
  assign o_ABLO     = cmd_q.ablo;
  assign o_DB       = cmd_q.data;
  assign o_RD_VALID = rd_valid_q;
  assign o_RD_DATA  = rd_data_q;
  assign o_BUSY     = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_ikascc_bus_sequencer.sv
// Directed bench for ikascc_bus_sequencer.
// Bus monitor logs each strobe cycle; checks use hand-computed values.
module tb_ikascc_bus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pcen_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [4:0] cmd_abhi = '0;
  logic [7:0] cmd_ablo = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] db_in = '0;
  logic       db_oe = 1'b0;

  logic       cmd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [4:0] abhi;
  logic [7:0] ablo;
  logic [7:0] db;

  ikascc_bus_sequencer dut (
    .i_EMUCLK      (clk),
    .i_RST_n       (rst_n),
    .i_MCLK_PCEN_n (pcen_n),
    .i_CMD_VALID   (cmd_valid),
    .o_CMD_READY   (cmd_ready),
    .i_CMD_RD      (cmd_rd),
    .i_CMD_ABHI    (cmd_abhi),
    .i_CMD_ABLO    (cmd_ablo),
    .i_CMD_DATA    (cmd_data),
    .o_RD_VALID    (rd_valid),
    .o_RD_DATA     (rd_data),
    .o_BUSY        (busy),
    .o_CS_n        (cs_n),
    .o_RD_n        (rd_n),
    .o_WR_n        (wr_n),
    .o_ABHI        (abhi),
    .o_ABLO        (ablo),
    .o_DB          (db),
    .i_DB          (db_in),
    .i_DB_OE       (db_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mode = 0;
  int ph = 0;
  logic rdy_seen = 1'b0;

  int ncyc = 0;
  int wr_low = 0;
  int rd_low = 0;
  int rdv = 0;
  int nev = 0;
  int last_chg = 0;
  logic prev_cs = 1'b1;
  logic [20:0] prev_bus = '0;
  int ev_cyc [64];
  int ev_setup [64];
  logic [21:0] ev_cmd [64];

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (!wr_n) wr_low <= wr_low + 1;
    if (!rd_n) rd_low <= rd_low + 1;
    if (rd_valid) rdv <= rdv + 1;
    if ({abhi, ablo, db} != prev_bus) last_chg <= ncyc;
    prev_bus <= {abhi, ablo, db};
    prev_cs <= cs_n;
    if (prev_cs && !cs_n && nev < 64) begin
      ev_cyc[nev]   <= ncyc;
      ev_setup[nev] <= ncyc - last_chg;
      ev_cmd[nev]   <= {~rd_n, abhi, ablo, db};
      nev <= nev + 1;
    end
  end

  int b_wr, b_rd, b_rdv, b_ev;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_wr  = wr_low;
    b_rd  = rd_low;
    b_rdv = rdv;
    b_ev  = nev;
  endtask

  task automatic step();
    pcen_n = !(mode == 2 || (mode == 1 && ph == 0));
    ph = (ph + 1) % 4;
    #1 rdy_seen = cmd_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic rd, input logic [4:0] hi,
                      input logic [7:0] lo, input logic [7:0] d,
                      output logic acc);
    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_abhi  = hi;
    cmd_ablo  = lo;
    cmd_data  = d;
    step();
    acc = rdy_seen;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (busy && n < maxc) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    step();
    step();
  endtask

  logic acc;

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    step();
    step();
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_rd_n", 32'(rd_n), 32'd1);
    check("rst_wr_n", 32'(wr_n), 32'd1);
    check("rst_abhi", 32'(abhi), 32'h0);
    check("rst_ablo", 32'(ablo), 32'h0);
    check("rst_db", 32'(db), 32'h0);
    check("rst_rdv", 32'(rd_valid), 32'd0);
    check("rst_rdata", 32'(rd_data), 32'hFF);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    step();

    // single write, ticks every 4th clock
    mode = 1;
    snap();
    push(1'b0, 5'h12, 8'h00, 8'h3F, acc);
    check("t1_acc", 32'(acc), 32'd1);
    wait_idle(200, "t1_idle");
    check("t1_nev", 32'(nev - b_ev), 32'd1);
    check("t1_cmd", 32'(ev_cmd[b_ev]), {10'd0, 1'b0, 5'h12, 8'h00, 8'h3F});
    check("t1_setup", 32'(ev_setup[b_ev]), 32'd4);
    check("t1_wr_low", 32'(wr_low - b_wr), 32'd12);
    check("t1_rd_low", 32'(rd_low - b_rd), 32'd0);
    check("t1_rdv", 32'(rdv - b_rdv), 32'd0);
    check("t1_hold_ab", 32'({abhi, db}), {19'd0, 5'h12, 8'h3F});

    // reads: output disabled then enabled
    db_in = 8'h5A;
    db_oe = 1'b0;
    snap();
    push(1'b1, 5'h13, 8'h80, 8'h00, acc);
    wait_idle(200, "t2a_idle");
    check("t2a_rdv", 32'(rdv - b_rdv), 32'd1);
    check("t2a_rdata", 32'(rd_data), 32'hFF);
    check("t2a_rd_low", 32'(rd_low - b_rd), 32'd12);
    db_oe = 1'b1;
    snap();
    push(1'b1, 5'h13, 8'h00, 8'h00, acc);
    wait_idle(200, "t2b_idle");
    check("t2b_rdv", 32'(rdv - b_rdv), 32'd1);
    check("t2b_rdata", 32'(rd_data), 32'h5A);
    check("t2b_wr_low", 32'(wr_low - b_wr), 32'd0);

    // fill with ticks stalled, then release
    mode = 0;
    snap();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 5'(i + 1), 8'(i), 8'(8'h20 + i), acc);
      check($sformatf("t3_acc%0d", i), 32'(acc), (i < 4) ? 32'd1 : 32'd0);
    end
    check("t3_ready", 32'(cmd_ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    mode = 1;
    wait_idle(600, "t3_idle");
    check("t3_nev", 32'(nev - b_ev), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_cmd%0d", k), 32'(ev_cmd[b_ev + k]),
            {10'd0, 1'b0, 5'(k + 1), 8'(k), 8'(8'h20 + k)});
      if (k > 0)
        check($sformatf("t3_gap%0d", k),
              32'(ev_cyc[b_ev + k] - ev_cyc[b_ev + k - 1]), 32'd32);
    end

    // push into a full FIFO on the popping tick
    mode = 0;
    snap();
    for (int i = 0; i < 4; i++)
      push(1'b0, 5'(9 + i), 8'(8'h40 + i), 8'(8'h50 + i), acc);
    check("t4_full_pre", 32'(cmd_ready), 32'd0);
    mode = 2;
    push(1'b0, 5'h1D, 8'h4F, 8'h5F, acc);
    mode = 0;
    check("t4_acc", 32'(acc), 32'd1);
    pcen_n = 1'b1;
    #1 check("t4_full_post", 32'(cmd_ready), 32'd0);
    mode = 2;
    wait_idle(200, "t4_idle");
    check("t4_nev", 32'(nev - b_ev), 32'd5);
    check("t4_last", 32'(ev_cmd[b_ev + 4]),
          {10'd0, 1'b0, 5'h1D, 8'h4F, 8'h5F});
    for (int k = 1; k < 5; k++)
      check($sformatf("t4_gap%0d", k),
            32'(ev_cyc[b_ev + k] - ev_cyc[b_ev + k - 1]), 32'd8);

    // back-to-back writes, every clock a tick
    snap();
    push(1'b0, 5'h03, 8'h11, 8'hA5, acc);
    push(1'b0, 5'h04, 8'h22, 8'h5A, acc);
    wait_idle(100, "t6_idle");
    check("t6_nev", 32'(nev - b_ev), 32'd2);
    check("t6_wr_low", 32'(wr_low - b_wr), 32'd6);
    check("t6_gap", 32'(ev_cyc[b_ev + 1] - ev_cyc[b_ev]), 32'd8);
    check("t6_setup", 32'(ev_setup[b_ev]), 32'd1);
    check("t6_cmd0", 32'(ev_cmd[b_ev]), {10'd0, 1'b0, 5'h03, 8'h11, 8'hA5});
    check("t6_cmd1", 32'(ev_cmd[b_ev + 1]), {10'd0, 1'b0, 5'h04, 8'h22, 8'h5A});
    check("t6_rdata_held", 32'(rd_data), 32'h5A);

    // reset in the middle of a read strobe
    mode = 1;
    db_oe = 1'b1;
    db_in = 8'hC3;
    push(1'b1, 5'h07, 8'h33, 8'h00, acc);
    push(1'b0, 5'h08, 8'h44, 8'h66, acc);
    begin
      int n = 0;
      while (cs_n && n < 100) begin
        step();
        n++;
      end
    end
    check("t5_in_strobe", 32'({cs_n, rd_n}), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t5_cs_n", 32'(cs_n), 32'd1);
    check("t5_rd_n", 32'(rd_n), 32'd1);
    check("t5_wr_n", 32'(wr_n), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    snap();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("t5_rdv", 32'(rdv - b_rdv), 32'd0);
    check("t5_nev", 32'(nev - b_ev), 32'd0);
    check("t5_rdata", 32'(rd_data), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
